// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: picks the amount source, captures the amount, loads the shifter and issues the shift.
// Optional rotate support (op 011/100) is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl #(
    parameter int SERIAL = 0,
    parameter int AMT_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [1:0]       amt_src,
    input  logic [AMT_W-1:0] shift_amt_in,
    output logic [1:0]       Shift_Amt,
    output logic [2:0]       shift_fn,
    output logic [AMT_W-1:0] shift_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_state_next;
    logic [2:0]       r_op, w_op_next;
    logic [1:0]       r_src, w_src_next;
    logic [AMT_W-1:0] r_amt, w_amt_next;
    logic [AMT_W-1:0] r_cnt, w_cnt_next;
    logic             w_op_ok, w_src_ok, w_err_next;
    logic [2:0]       w_fn_op;

    logic [1:0]       w_shift_amt_next;
    logic [2:0]       w_shift_fn_next;
    logic [AMT_W-1:0] w_shift_n_next;
    logic             w_busy_next, w_done_next;

    always_comb begin
        w_src_ok = (amt_src != 2'b11);
        case (op)
            3'b000, 3'b001, 3'b010: w_op_ok = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
            3'b011, 3'b100:         w_op_ok = 1'b1;
`endif
            default:                w_op_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (r_op)
            3'b000:  w_fn_op = 3'b010;
            3'b001:  w_fn_op = 3'b011;
            3'b010:  w_fn_op = 3'b100;
`ifdef SHIFT_SEQ_ROTATE_EN
            3'b011:  w_fn_op = 3'b101;
            3'b100:  w_fn_op = 3'b110;
`endif
            default: w_fn_op = 3'b000;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_op_next    = r_op;
        w_src_next   = r_src;
        w_amt_next   = r_amt;
        w_cnt_next   = r_cnt;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_op_ok && w_src_ok) begin
                        w_op_next    = op;
                        w_src_next   = amt_src;
                        w_state_next = S_SEL;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_SEL: begin
                w_amt_next   = shift_amt_in;
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                // A zero amount only loads; no shift command is issued.
                if (r_amt != '0) begin
                    w_cnt_next   = r_amt;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_SHIFT: begin
                if (SERIAL == 0 || r_cnt == AMT_W'(1)) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - AMT_W'(1);
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        w_shift_amt_next = 2'b00;
        w_shift_fn_next  = 3'b000;
        w_shift_n_next   = '0;
        w_busy_next      = 1'b0;
        w_done_next      = 1'b0;
        if (w_state_next != S_IDLE && !w_err_next) begin
            w_shift_amt_next = w_src_next;
        end
        case (w_state_next)
            S_SEL:   w_busy_next = 1'b1;
            S_LOAD: begin
                w_busy_next     = 1'b1;
                w_shift_fn_next = 3'b001;
            end
            S_SHIFT: begin
                w_busy_next     = 1'b1;
                w_shift_fn_next = w_fn_op;
                w_shift_n_next  = (SERIAL != 0) ? AMT_W'(1) : r_amt;
            end
            S_DONE:  w_done_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_op      <= 3'b000;
            r_src     <= 2'b00;
            r_amt     <= '0;
            r_cnt     <= '0;
            Shift_Amt <= 2'b00;
            shift_fn  <= 3'b000;
            shift_n   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_op      <= w_op_next;
            r_src     <= w_src_next;
            r_amt     <= w_amt_next;
            r_cnt     <= w_cnt_next;
            Shift_Amt <= w_shift_amt_next;
            shift_fn  <= w_shift_fn_next;
            shift_n   <= w_shift_n_next;
            busy      <= w_busy_next;
            done      <= w_done_next;
            err       <= w_err_next;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: one single-command and one serial instance on shared inputs.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = 3'b000;
    logic [1:0] amt_src = 2'b00;
    logic [4:0] shift_amt_in = 5'd0;

    logic [1:0] sa0, sa1;
    logic [2:0] fn0, fn1;
    logic [4:0] n0, n1;
    logic       busy0, busy1, done0, done1, err0, err1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.SERIAL(0), .AMT_W(5)) u0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .amt_src(amt_src),
        .shift_amt_in(shift_amt_in), .Shift_Amt(sa0), .shift_fn(fn0), .shift_n(n0),
        .busy(busy0), .done(done0), .err(err0));

    shift_seq_ctrl #(.SERIAL(1), .AMT_W(5)) u1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .amt_src(amt_src),
        .shift_amt_in(shift_amt_in), .Shift_Amt(sa1), .shift_fn(fn1), .shift_n(n1),
        .busy(busy1), .done(done1), .err(err1));

    typedef struct {
        logic [2:0] op;
        logic [1:0] src;
        logic [4:0] amt;
        logic [2:0] exp_fn;   // shift_fn in the shift cycle
        logic       exp_err;
        int         done_cyc; // cycle of done, start sampled at edge 0
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic launch(input logic [2:0] o, input logic [1:0] s, input logic [4:0] a);
        @(negedge clk);
        op = o; amt_src = s; shift_amt_in = a; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int dones_a, dones_b, done_at;

        vecs[0] = '{3'b000, 2'b01, 5'd5,  3'b010, 1'b0, 4};
        vecs[1] = '{3'b001, 2'b00, 5'd0,  3'b000, 1'b0, 3};
        vecs[2] = '{3'b010, 2'b10, 5'd31, 3'b100, 1'b0, 4};
        vecs[3] = '{3'b110, 2'b00, 5'd5,  3'b000, 1'b1, 1};
        vecs[4] = '{3'b000, 2'b11, 5'd5,  3'b000, 1'b1, 1};
        vecs[5] = '{3'b111, 2'b01, 5'd2,  3'b000, 1'b1, 1};
        vecs[6] = '{3'b001, 2'b10, 5'd1,  3'b011, 1'b0, 4};
`ifdef SHIFT_SEQ_ROTATE_EN
        vecs[7] = '{3'b100, 2'b01, 5'd4,  3'b110, 1'b0, 4};
        vecs[8] = '{3'b011, 2'b10, 5'd7,  3'b101, 1'b0, 4};
`else
        vecs[7] = '{3'b100, 2'b01, 5'd4,  3'b000, 1'b1, 1};
        vecs[8] = '{3'b011, 2'b10, 5'd7,  3'b000, 1'b1, 1};
`endif

        // Reset state
        @(negedge clk);
        chk("reset outs u0", {sa0, fn0, n0, busy0, done0, err0}, 0);
        chk("reset outs u1", {sa1, fn1, n1, busy1, done1, err1}, 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            launch(v.op, v.src, v.amt);
            for (int c = 1; c <= 5; c++) begin
                int dc;
                dc = v.done_cyc;
                if (c > 1) @(negedge clk);
                chk($sformatf("v%0d c%0d done", i, c), done0, (c == dc) ? 1 : 0);
                chk($sformatf("v%0d c%0d err", i, c), err0, (c == dc && v.exp_err) ? 1 : 0);
                chk($sformatf("v%0d c%0d busy", i, c), busy0, (c < dc) ? 1 : 0);
                chk($sformatf("v%0d c%0d sel", i, c), sa0,
                    (c <= dc && !v.exp_err) ? int'(v.src) : 0);
                chk($sformatf("v%0d c%0d fn", i, c), fn0,
                    (c == 2 && !v.exp_err) ? 1 : ((c == 3 && dc == 4) ? int'(v.exp_fn) : 0));
                if (c == 3 && dc == 4)
                    chk($sformatf("v%0d shift_n", i), n0, int'(v.amt));
            end
            $display("vec %0d op=%b src=%b amt=%0d err=%0d done_cyc=%0d", i, v.op, v.src, v.amt,
                     v.exp_err, v.done_cyc);
            do_reset();
        end

        // Serial N=3 sra: three one-bit commands in cycles 3..5, done in 6
        launch(3'b010, 2'b00, 5'd3);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            chk($sformatf("ser c%0d busy", c), busy1, (c <= 5) ? 1 : 0);
            chk($sformatf("ser c%0d done", c), done1, (c == 6) ? 1 : 0);
            chk($sformatf("ser c%0d err", c), err1, 0);
            chk($sformatf("ser c%0d fn", c), fn1, (c == 2) ? 1 : ((c >= 3 && c <= 5) ? 4 : 0));
            if (c >= 3 && c <= 5) chk($sformatf("ser c%0d shift_n", c), n1, 1);
        end
        $display("serial sra N=3 sequence done");
        do_reset();

        // Reset in the middle of a serial N=20 shift: immediate clear, no done afterwards
        launch(3'b000, 2'b10, 5'd20);
        for (int c = 2; c <= 8; c++) @(negedge clk);
        chk("mid shift fn", fn1, 2);
        chk("mid shift sel", sa1, 2);
        reset = 1'b1;
        #1;
        chk("async reset outs", {sa1, fn1, n1, busy1, done1, err1}, 0);
        @(negedge clk);
        reset = 1'b0;
        dones_a = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done1) dones_a++;
        end
        chk("no done after reset", dones_a, 0);
        $display("reset during serial N=20 shift");

        // Start pulses while busy / in DONE are ignored
        launch(3'b000, 2'b01, 5'd5);
        dones_a = 0; dones_b = 0; done_at = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) @(negedge clk);
            if (done0) dones_a++;
            if (done1) begin
                dones_b++;
                done_at = c;
            end
            start = (c == 2 || c == 4);
            if (start) begin
                op = 3'b001; amt_src = 2'b00; shift_amt_in = 5'd7;
            end
        end
        start = 1'b0;
        chk("busy start dones u0", dones_a, 1);
        chk("busy start dones u1", dones_b, 1);
        chk("busy start done cyc u1", done_at, 8);
        $display("start while busy ignored");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
